// File: rtl/can_pkg.sv
// Shared CAN definitions used by the bit stuffer and its line monitor.
//   CAN_STUFF_LEN  : default run length that forces a stuff bit
//   CAN_RECESSIVE  : logic level of a recessive bus bit
//   CAN_DOMINANT   : logic level of a dominant bus bit
//   can_tx_state_e : transmit-side line state (IDLE / SEND)
package can_pkg;

    localparam int   CAN_STUFF_LEN = 5;
    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } can_tx_state_e;

endpackage : can_pkg

// File: rtl/can_bit_monitor.sv
// Sample-point monitor for the CAN transmit line.
// Compares the bus RX level against the bit being driven and pulses
// bit_error one clk after a mismatching sample_tick.
// Ports:
//   clk, rst     : clock, async active-high reset
//   txing        : frame in progress
//   bit_tick     : start of bit time (suppresses a coincident sample)
//   sample_tick  : sample point strobe
//   cmp_load     : load cmp_en with cmp_val (issued on each driven bit)
//   cmp_val      : compare enable for the bit now being driven
//   rx           : synchronised bus RX level
//   can_tx       : registered TX level currently on the line
//   bit_error    : one-clk mismatch pulse
module can_bit_monitor
    import can_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic txing,
    input  logic bit_tick,
    input  logic sample_tick,
    input  logic cmp_load,
    input  logic cmp_val,
    input  logic rx,
    input  logic can_tx,
    output logic bit_error
);

    logic cmp_en_q;
    logic cmp_en_d;
    logic bit_error_q;
    logic bit_error_d;

    // Next-state for the compare enable and the error pulse.
    always_comb begin
        cmp_en_d    = cmp_en_q;
        bit_error_d = 1'b0;
        if (!txing) begin
            cmp_en_d = 1'b0;
        end else if (cmp_load) begin
            cmp_en_d = cmp_val;
        end else begin
            cmp_en_d = cmp_en_q;
        end
        // A sample landing on a bit_tick is a misconfiguration; the new bit
        // has not been driven yet, so no compare is made.
        if (sample_tick && !bit_tick && txing && cmp_en_q && (rx != can_tx)) begin
            bit_error_d = 1'b1;
        end else begin
            bit_error_d = 1'b0;
        end
    end

    // Monitor state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_en_q    <= 1'b0;
            bit_error_q <= 1'b0;
        end else begin
            cmp_en_q    <= cmp_en_d;
            bit_error_q <= bit_error_d;
        end
    end

    assign bit_error = bit_error_q;

endmodule : can_bit_monitor

// File: rtl/can_bit_stuffer.sv
// CAN transmit bit stuffer. Takes one frame bit per bit time from the TX FSM,
// inserts a complementary stuff bit after STUFF_LEN identical line bits in the
// stuffed region (withholding bit_ack so upstream holds its bit), and drives
// the registered TX line. A sub-monitor flags RX/TX mismatches.
// Ports:
//   clk, rst     : clock, async active-high reset
//   bit_tick     : start of each bit time
//   sample_tick  : sample point within the bit time
//   txing        : frame in progress
//   stuff_en     : current bit lies in the stuffed region
//   bit_in       : current frame bit from upstream
//   bit_ack      : one-clk pulse, bit_in consumed
//   can_tx       : registered TX line (1 = recessive)
//   stuff_active : high for the whole bit time of an inserted stuff bit
//   rx           : synchronised bus RX level
//   bit_error    : one-clk monitor mismatch pulse
module can_bit_stuffer
    import can_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_tick,
    input  logic sample_tick,
    input  logic txing,
    input  logic stuff_en,
    input  logic bit_in,
    output logic bit_ack,
    output logic can_tx,
    output logic stuff_active,
    input  logic rx,
    output logic bit_error
);

    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0] RUN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RUN_ZERO = {CNT_W{1'b0}};

    can_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             last_bit_q, last_bit_d;
    logic             can_tx_q, can_tx_d;
    logic             bit_ack_q, bit_ack_d;
    logic             stuff_active_q, stuff_active_d;
    logic             go_idle_s;
    logic             do_pass_s;
    logic             do_stuff_s;
    logic             cmp_load_s;
    logic             cmp_val_s;

    // Line state decode, run counter and stuff insertion.
    always_comb begin
        state_d        = state_q;
        run_cnt_d      = run_cnt_q;
        last_bit_d     = last_bit_q;
        can_tx_d       = can_tx_q;
        bit_ack_d      = 1'b0;
        stuff_active_d = stuff_active_q;
        go_idle_s      = 1'b0;
        do_pass_s      = 1'b0;
        do_stuff_s     = 1'b0;
        cmp_load_s     = 1'b0;
        cmp_val_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (txing) begin
                    // run_cnt is 0 here, so the first bit can only be a pass.
                    state_d   = SEND;
                    do_pass_s = bit_tick;
                end else begin
                    go_idle_s = 1'b1;
                end
            end
            SEND: begin
                if (!txing) begin
                    state_d   = IDLE;
                    go_idle_s = 1'b1;
                end else if (bit_tick) begin
                    if ((run_cnt_q == RUN_MAX) && stuff_en) begin
                        do_stuff_s = 1'b1;
                    end else begin
                        do_pass_s = 1'b1;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d   = IDLE;
                go_idle_s = 1'b1;
            end
        endcase

        if (go_idle_s) begin
            can_tx_d       = CAN_RECESSIVE;
            run_cnt_d      = RUN_ZERO;
            last_bit_d     = CAN_RECESSIVE;
            stuff_active_d = 1'b0;
        end else if (do_stuff_s) begin
            // The stuff bit opens a new run of the opposite level.
            can_tx_d       = ~last_bit_q;
            last_bit_d     = ~last_bit_q;
            run_cnt_d      = RUN_ONE;
            stuff_active_d = 1'b1;
            cmp_load_s     = 1'b1;
            cmp_val_s      = 1'b1;
        end else if (do_pass_s) begin
            can_tx_d       = bit_in;
            bit_ack_d      = 1'b1;
            last_bit_d     = bit_in;
            stuff_active_d = 1'b0;
            cmp_load_s     = 1'b1;
            cmp_val_s      = stuff_en;
            // Saturate so unstuffed tails (EOF etc.) never wrap the counter.
            if ((bit_in == last_bit_q) && (run_cnt_q != RUN_ZERO)) begin
                if (run_cnt_q == RUN_MAX) begin
                    run_cnt_d = RUN_MAX;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_ONE;
                end
            end else begin
                run_cnt_d = RUN_ONE;
            end
        end else begin
            run_cnt_d = run_cnt_q;
        end
    end

    // Stuffer state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            run_cnt_q      <= RUN_ZERO;
            last_bit_q     <= CAN_RECESSIVE;
            can_tx_q       <= CAN_RECESSIVE;
            bit_ack_q      <= 1'b0;
            stuff_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            run_cnt_q      <= run_cnt_d;
            last_bit_q     <= last_bit_d;
            can_tx_q       <= can_tx_d;
            bit_ack_q      <= bit_ack_d;
            stuff_active_q <= stuff_active_d;
        end
    end

    assign can_tx       = can_tx_q;
    assign bit_ack      = bit_ack_q;
    assign stuff_active = stuff_active_q;

    can_bit_monitor u_monitor (
        .clk         (clk),
        .rst         (rst),
        .txing       (txing),
        .bit_tick    (bit_tick),
        .sample_tick (sample_tick),
        .cmp_load    (cmp_load_s),
        .cmp_val     (cmp_val_s),
        .rx          (rx),
        .can_tx      (can_tx_q),
        .bit_error   (bit_error)
    );

endmodule : can_bit_stuffer
